// File: rtl/pila_pkg.sv
// Shared definitions for the return-address stack and its neighbours
// (PC path, control unit): default widths, the address type and the
// command encoding seen by the stack.
package pila_pkg;

    // Default address width; matches the PC width.
    localparam int PILA_ADDR_W = 10;

    // Default number of stack entries; power of two, at least 2.
    localparam int PILA_DEPTH  = 16;

    // Return address as carried between PC path, control unit and stack.
    typedef logic [PILA_ADDR_W-1:0] addr_t;

    // Command presented by the control unit in a given cycle, encoded as
    // {push, pop}.
    typedef enum logic [1:0] {
        OP_HOLD    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } stack_op_e;

    // Map the two raw command strobes onto the command enum.
    function automatic stack_op_e decode_op(input logic push, input logic pop);
        return stack_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/pila_ram.sv
// Storage array of the return-address stack: DEPTH x ADDR_W registers,
// one synchronous write port and one asynchronous read port.
module pila_ram #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] mem [DEPTH];

    // Write the addressed entry on the rising edge when enabled.
    // NOTE: the array has no reset on purpose; the top masks q while the
    // stack is empty, so stale contents are never observable and the array
    // can map onto plain flops or LUT RAM without a reset tree.
    always_ff @(posedge clk) begin
        if (we) begin
            // NOTE: state inside clocked blocks is always updated with <=, so
            // every register samples the pre-edge values of its inputs.
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read so the top entry is visible in the same cycle.
    assign rdata = mem[raddr];

endmodule

// File: rtl/pila_retorno.sv
// Hardware return-address stack (LIFO) for the CPU control unit.
// push stores d (PC+1) on top; pop removes the top entry. q always shows
// the current top so the PC next-address mux can take it during the pop
// cycle. sp points at the next free slot; level == sp; full/empty are
// decoded from sp. Over/underflow requests are ignored and never disturb
// valid entries.
// Optional build macro PILA_STACK_ERR_EN adds sticky ovf/unf flags and the
// err_clr input that clears them.
module pila_retorno
    import pila_pkg::*;
#(
    parameter int ADDR_W = PILA_ADDR_W,
    parameter int DEPTH  = PILA_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] d,
`ifdef PILA_STACK_ERR_EN
    input  logic              err_clr,
    output logic              ovf,
    output logic              unf,
`endif
    output logic [ADDR_W-1:0] q,
    output logic              empty,
    output logic              full,
    output logic [PTR_W-1:0]  level
);

    // Index width of the storage array.
    localparam int AW = $clog2(DEPTH);

    stack_op_e         op;
    logic [PTR_W-1:0]  sp;
    logic [PTR_W-1:0]  sp_next;
    logic [AW-1:0]     free_idx;
    logic [AW-1:0]     top_idx;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [ADDR_W-1:0] rdata;

    assign op = decode_op(push, pop);

    // Status decoded straight from the pointer; nothing stored twice.
    assign empty = (sp == '0);
    assign full  = (sp == PTR_W'(DEPTH));
    assign level = sp;

    // Next free slot and current top. sp never exceeds DEPTH, so sp-1 always
    // fits the array index whenever the stack is non-empty; when empty the
    // read index is meaningless and q is masked below.
    assign free_idx = sp[AW-1:0];
    assign top_idx  = AW'(sp - PTR_W'(1));

    // Pointer update and write-port control for the current command.
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch can be inferred.
    always_comb begin
        sp_next = sp;
        we      = 1'b0;
        waddr   = free_idx;
        unique case (op)
            OP_PUSH: begin
                // A push into a full stack is dropped.
                if (!full) begin
                    we      = 1'b1;
                    sp_next = sp + PTR_W'(1);
                end
            end
            OP_POP: begin
                // A pop from an empty stack is dropped.
                if (!empty) begin
                    sp_next = sp - PTR_W'(1);
                end
            end
            OP_REPLACE: begin
                if (empty) begin
                    // Nothing to replace: behave as a plain push.
                    we      = 1'b1;
                    sp_next = sp + PTR_W'(1);
                end else begin
                    // Overwrite the top in place; depth unchanged.
                    we      = 1'b1;
                    waddr   = top_idx;
                end
            end
            default: begin
                // OP_HOLD: keep everything.
            end
        endcase
    end

    // Stack pointer register; reset drops any in-flight command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else begin
            sp <= sp_next;
        end
    end

    pila_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk    (clk),
        .we     (we),
        .waddr  (waddr),
        .wdata  (d),
        .raddr  (top_idx),
        .rdata  (rdata)
    );

    // Top of stack, forced to zero while the stack holds nothing.
    assign q = empty ? '0 : rdata;

`ifdef PILA_STACK_ERR_EN
    logic ovf_evt;
    logic unf_evt;

    // Error events: only a lone push/pop can over/underflow; a combined
    // push+pop on an empty stack is a legal push.
    assign ovf_evt = (op == OP_PUSH) && full;
    assign unf_evt = (op == OP_POP)  && empty;

    // Sticky error flags; a new event in the clearing cycle takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (ovf_evt) begin
                ovf <= 1'b1;
            end else if (err_clr) begin
                ovf <= 1'b0;
            end
            if (unf_evt) begin
                unf <= 1'b1;
            end else if (err_clr) begin
                unf <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: doc/pila_retorno.md
Name: pila_retorno

Overview:
- Hardware return-address stack (LIFO) that executes the push/pop commands issued by the CPU control unit.
- On push it stores the return address supplied by the PC path.
- It continuously presents the top-of-stack address to the PC next-address mux. The control unit selects that mux input (s_pila) in the pop cycle.
- Sits between the control unit and the PC register, beside the PC incrementer.

Parameters:
- ADDR_W, 10, width of a stored address (matches PC width).
- DEPTH, 16, number of entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH)+1, width of the stack pointer and level output.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  store d on top of stack this cycle.
- pop  input  1  remove top entry this cycle.
- d  input  ADDR_W  return address to store (PC+1 from the incrementer).
- q  output  ADDR_W  current top-of-stack address, combinational from registered state.
- empty  output  1  high when level == 0.
- full  output  1  high when level == DEPTH.
- level  output  PTR_W  number of valid entries.
- ovf  output  1  sticky overflow flag (STACK_ERR_EN only).
- unf  output  1  sticky underflow flag (STACK_ERR_EN only).
- err_clr  input  1  synchronous clear of ovf/unf (STACK_ERR_EN only).

Behaviour:
- Reset values (asynchronous): sp=0, level=0, empty=1, full=0, q=0, ovf=0, unf=0. Array contents are not reset; q is forced to 0 while empty.
- Reset during an operation: state is cleared immediately and the in-flight push/pop is lost.
- Stack pointer: sp points at the next free slot, so top = mem[sp-1].
- q timing:
  - q = mem[sp-1] when not empty, else 0.
  - Zero-latency read: the pop cycle sees the top entry on q. The PC captures q at the same edge on which sp decrements.
- push only:
  - Not full: mem[sp] <= d, sp <= sp+1. The new value appears on q the next cycle.
  - Full: no write, sp unchanged; ovf <= 1 (if enabled).
- pop only:
  - Not empty: sp <= sp-1.
  - Empty: sp unchanged, q stays 0; unf <= 1 (if enabled).
- push and pop in the same cycle (replace top):
  - Not empty: mem[sp-1] <= d, sp unchanged. q shows the old top this cycle and d the next cycle.
  - Empty: treated as push only, and unf is not set.
- Neither asserted: hold.
- level == sp. full and empty are decoded from sp, not stored separately.
- No wrap-around: sp saturates within 0..DEPTH. Over/underflow never corrupts valid entries.
- All state updates happen on the rising edge of clk; no combinational path exists from push/pop to q.

Optional Feature:
- Macro: PILA_STACK_ERR_EN.
- Defined:
  - ovf and unf are sticky registers, set per the rules above.
  - err_clr=1 clears both on the next edge.
  - If err_clr coincides with a new error in the same cycle, the set wins.
- Undefined:
  - The ovf, unf and err_clr ports are absent.
  - Boundary behaviour (ignore push when full, ignore pop when empty) is unchanged.

Decomposition:
- Shared package pila_pkg holds the default ADDR_W/DEPTH constants and the addr_t typedef, reused by the PC path and control unit.
- One natural sub-module: pila_ram.
  - DEPTH x ADDR_W register array with one synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
- The top level holds sp, the next-state logic, flags and the q masking.

Test Plan:
- Reset then idle -> q=0, empty=1, full=0, level=0.
- Push d=0x005, then push d=0x123 -> level=2, q=0x123. Pop -> q was 0x123 during the pop cycle; after the edge q=0x005, level=1.
- Push 16 distinct values 0x100..0x10F, then one extra push of 0x3FF -> full=1, level=16, q=0x10F, ovf=1. Then 16 pops return 0x10F..0x100 in order and empty=1.
- Pop on an empty stack -> level stays 0, q=0, unf=1. Then err_clr=1 -> unf=0 next cycle.
- With level=3 and top 0x0A0, assert push and pop together with d=0x0B0 -> level stays 3, q=0x0B0 next cycle, the entry below is unchanged.
- Assert reset asynchronously mid-sequence at level=5 -> level=0, q=0 and empty=1 before the next clock edge.
